// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver
//
// Receive-side counterpart of uart_tx, sitting at the board-level rs232 input
// pin. The serial line is synchronised into the clk domain, a falling edge
// opens a frame, the start bit is re-checked at mid-bit to reject glitches,
// eight data bits are sampled LSB-first at mid-bit and the stop bit is
// checked. A good frame updates data and pulses done for one cycle; a frame
// whose stop bit is low pulses frame_err and leaves data untouched.
//
// Parameters
//   CLK_FREQ  system clock frequency in Hz
//   BAUD      line rate in bit/s
//   BAUD_CNT  clocks per bit (>= 8), defaults to CLK_FREQ/BAUD
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous reset, active-high
//   rs232_rx   in   1  serial line, idle high, asynchronous to clk
//   data       out  8  last correctly received byte
//   done       out  1  1-cycle pulse: new valid byte on data
//   frame_err  out  1  1-cycle pulse: stop bit sampled low, byte discarded
//   busy       out  1  high while a frame is being received
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned BAUD_CNT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232_rx,
    output logic [7:0] data,
    output logic       done,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned HALF  = BAUD_CNT / 2;
    localparam int unsigned CNT_W = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    // Two-flop synchroniser plus one delay flop for edge detection.
    // All preset to 1 so reset looks like an idle line and cannot fake a
    // falling edge.
    logic rx_meta;
    logic rx_sync;
    logic rx_d;
    logic rx_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rs232_rx;
            rx_sync <= rx_meta;
            rx_d    <= rx_sync;
        end
    end

    assign rx_fall = rx_d & ~rx_sync;

    // Receive FSM. The start bit is checked at its midpoint, after which the
    // counter is restarted so every later sample lands one full bit period
    // later, i.e. at the middle of each data bit and of the stop bit.
    // The FSM returns to IDLE at mid stop bit so a start bit that follows
    // immediately is still caught by its falling edge. A line held low
    // after a bad frame never produces a falling edge, so a break does not
    // repeat frame_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done      <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rx_fall) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            // Line back high at mid start bit: glitch.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        // LSB arrives first, so shift in from the top.
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (rx_sync) begin
                            data <= shreg;
                            done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx (BAUD_CNT = 16, 20 ns clock)
//
// A serial driver task builds 8N1 frames on rs232_rx and pushes the expected
// outcome (byte or frame error, plus the time the start bit began) into a
// queue. An independent monitor pops that queue whenever done or frame_err
// fires and compares kind, byte, and latency; it also checks that data holds
// between done pulses and that pulses are exclusive and never back to back.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int unsigned BC   = 16;
    localparam int unsigned HALF = BC / 2;
    localparam int unsigned LAT  = 3 + HALF + 9 * BC;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       rs232_rx = 1'b1;
    logic [7:0] data;
    logic       done;
    logic       frame_err;
    logic       busy;

    uart_rx #(.BAUD_CNT(BC)) dut (
        .clk       (clk),
        .rst       (rst),
        .rs232_rx  (rs232_rx),
        .data      (data),
        .done      (done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [7:0]  d;
        int unsigned start;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  ref_data = 8'h00;
    bit          prev_evt = 1'b0;
    bit          b2b_mode = 1'b0;
    bit          seen_fall = 1'b0;
    bit          busy_prev = 1'b0;
    int unsigned low_run = 0;
    int unsigned gap_checks = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (done || frame_err) begin
                exp_t        e;
                int unsigned lat;
                chk(!(done && frame_err), "exclusive", {done, frame_err}, 32'h2);
                chk(!prev_evt, "no_consecutive", prev_evt, 0);
                chk(exp_q.size() != 0, "unexpected_output", {done, frame_err}, 0);
                if (exp_q.size() != 0) begin
                    e   = exp_q.pop_front();
                    lat = cyc - e.start;
                    chk(frame_err == e.is_err, "kind_frame_err", frame_err, e.is_err);
                    chk(lat >= LAT - 1 && lat <= LAT + 1, "latency", lat, LAT);
                    if (!e.is_err && done) begin
                        chk(data == e.d, "data", data, e.d);
                        ref_data = e.d;
                    end
                end
            end
            if (!done) chk(data == ref_data, "data_hold", data, ref_data);
            prev_evt = done || frame_err;

            if (!busy) begin
                if (busy_prev && b2b_mode) seen_fall = 1'b1;
                low_run++;
            end else begin
                if (!busy_prev && b2b_mode && seen_fall) begin
                    gap_checks++;
                    chk(low_run <= HALF + 3, "b2b_busy_gap", low_run, HALF + 3);
                end
                low_run = 0;
            end
            busy_prev = busy;
        end else begin
            prev_evt = 1'b0;
        end
    end

    task automatic drive_bit(input logic v, input int unsigned n);
        rs232_rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame at the given bit period. A bad stop bit may be followed
    // by a low hold (break), then the line returns high for one bit.
    task automatic send_frame(input logic [7:0] b, input int unsigned per,
                              input bit stop_ok, input int unsigned low_after);
        exp_t e;
        e.is_err = !stop_ok;
        e.d      = b;
        e.start  = cyc;
        exp_q.push_back(e);
        drive_bit(1'b0, per);
        for (int i = 0; i < 8; i++) drive_bit(b[i], per);
        drive_bit(stop_ok, per);
        if (!stop_ok) begin
            drive_bit(1'b0, low_after);
            drive_bit(1'b1, per);
        end
    endtask

    initial begin
        bit saw_busy;
        int unsigned w;
        logic [7:0] rb;
        bit ok;

        // Reset values
        repeat (3) @(negedge clk);
        chk(data == 8'h00, "reset_data", data, 0);
        chk(done == 1'b0, "reset_done", done, 0);
        chk(frame_err == 1'b0, "reset_frame_err", frame_err, 0);
        chk(busy == 1'b0, "reset_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive_bit(1'b1, 5);

        // Spaced frames
        send_frame(8'h55, BC, 1'b1, 0); drive_bit(1'b1, 20);
        send_frame(8'h58, BC, 1'b1, 0); drive_bit(1'b1, 20);
        send_frame(8'hB8, BC, 1'b1, 0); drive_bit(1'b1, 20);

        // Back-to-back frames, zero idle bits
        b2b_mode  = 1'b1;
        seen_fall = 1'b0;
        send_frame(8'h55, BC, 1'b1, 0);
        send_frame(8'h58, BC, 1'b1, 0);
        send_frame(8'hB8, BC, 1'b1, 0);
        drive_bit(1'b1, BC);
        b2b_mode = 1'b0;
        drive_bit(1'b1, 20);

        // Start-bit glitch
        rs232_rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rs232_rx = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        chk(saw_busy, "glitch_busy_pulse", saw_busy, 1);
        chk(busy == 1'b0, "glitch_back_idle", busy, 0);
        @(posedge clk); #1;

        // Bad stop bit, then a good frame
        send_frame(8'hA5, BC, 1'b0, 0); drive_bit(1'b1, 20);
        send_frame(8'h3C, BC, 1'b1, 0); drive_bit(1'b1, 20);

        // Bad stop bit followed by a long break
        send_frame(8'h96, BC, 1'b0, 5 * BC); drive_bit(1'b1, 20);
        send_frame(8'h11, BC, 1'b1, 0); drive_bit(1'b1, 20);

        // Reset in the middle of the data bits of 8'hFF
        drive_bit(1'b0, BC);
        drive_bit(1'b1, 2 * BC + 5);
        rst = 1'b1;
        ref_data = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(busy == 1'b0, "busy_in_reset", busy, 0);
            chk(done == 1'b0 && frame_err == 1'b0, "pulse_in_reset", {done, frame_err}, 0);
            chk(data == 8'h00, "data_in_reset", data, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drive_bit(1'b1, 20);
        send_frame(8'h81, BC, 1'b1, 0); drive_bit(1'b1, 20);

        // Sender clock offset
        send_frame(8'hC3, BC - 1, 1'b1, 0); drive_bit(1'b1, 30);
        send_frame(8'hC3, BC + 1, 1'b1, 0); drive_bit(1'b1, 30);

        // Random traffic
        for (int n = 0; n < 24; n++) begin
            rb = 8'($urandom);
            ok = ($urandom_range(5) != 0);
            send_frame(rb, BC, ok, $urandom_range(3) * BC);
            if ($urandom_range(2) == 0) drive_bit(1'b1, 0);
            else drive_bit(1'b1, $urandom_range(40));
        end
        drive_bit(1'b1, 20);

        // Drain with a bound
        w = 0;
        while (exp_q.size() != 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
        chk(gap_checks == 2, "b2b_gap_count", gap_checks, 2);
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
